// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer: prescaled down-counter with auto-reload or one-shot,
// a write-1-to-clear expiry flag and a level interrupt.
module apb_timer_slave #(
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 8
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Irq
);
    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_LOAD     = 3'd1;
    localparam logic [2:0] A_COUNT    = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_PRESCALE = 3'd4;

    logic                 en, reload, irqen, exp_flag;
    logic [CNT_WIDTH-1:0] load_val, count;
    logic [PRE_WIDTH-1:0] prescale, pre_cnt;
    logic                 addr_ok, wr, tick, expire;
    logic                 wr_ctrl, wr_load, wr_status, wr_pre;
    logic [2:0]           idx;
    logic                 unused_bits;

    assign addr_ok   = (Paddr[11:5] == 7'd0);
    assign idx       = Paddr[4:2];
    assign wr        = Psel & Penable & Pwrite & addr_ok;
    assign wr_ctrl   = wr & (idx == A_CTRL);
    assign wr_load   = wr & (idx == A_LOAD);
    assign wr_status = wr & (idx == A_STATUS);
    assign wr_pre    = wr & (idx == A_PRESCALE);

    assign tick   = en & (pre_cnt == prescale);
    assign expire = tick & (count == '0);

    // Interrupt depends on flops only, so it cannot glitch on bus activity.
    assign Irq = exp_flag & irqen;

    assign unused_bits = ^{Paddr[31:12], Paddr[1:0], Pwdata};

    always_comb begin
        Prdata = '0;
        if (!Hreset && Psel && !Pwrite && addr_ok) begin
            case (idx)
                A_CTRL:     Prdata = {29'd0, irqen, reload, en};
                A_LOAD:     Prdata[CNT_WIDTH-1:0] = load_val;
                A_COUNT:    Prdata[CNT_WIDTH-1:0] = count;
                A_STATUS:   Prdata = {31'd0, exp_flag};
                A_PRESCALE: Prdata[PRE_WIDTH-1:0] = prescale;
                default:    Prdata = '0;
            endcase
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            irqen    <= 1'b0;
            exp_flag <= 1'b0;
            load_val <= '0;
            count    <= '0;
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            // A CTRL write overrides the one-shot auto-disable on the same edge.
            if (wr_ctrl) begin
                en     <= Pwdata[0];
                reload <= Pwdata[1];
                irqen  <= Pwdata[2];
            end else if (expire && !reload) begin
                en <= 1'b0;
            end

            // Enabling restarts the prescaler so the first tick is a full period away.
            if (wr_ctrl && Pwdata[0] && !en) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + PRE_WIDTH'(1);
            end

            if (wr_load) begin
                load_val <= Pwdata[CNT_WIDTH-1:0];
                count    <= Pwdata[CNT_WIDTH-1:0];
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - CNT_WIDTH'(1);
                end else if (reload) begin
                    count <= load_val;
                end
            end

            // Setting the flag has priority over a simultaneous W1C.
            if (expire) begin
                exp_flag <= 1'b1;
            end else if (wr_status && Pwdata[0]) begin
                exp_flag <= 1'b0;
            end

            if (wr_pre) begin
                prescale <= Pwdata[PRE_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: register vector table plus timed sequences for the
// one-shot, auto-reload, collision, reset and bridge-style scenarios.
`timescale 1ns/100ps
module tb_apb_timer_slave;
    logic        Hclk, Hreset, Psel, Penable, Pwrite, Irq;
    logic [31:0] Paddr, Pwdata, Prdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[15];

    apb_timer_slave #(.CNT_WIDTH(32), .PRE_WIDTH(8)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Irq(Irq)
    );

    initial begin
        Hclk = 1'b0;
        forever #10 Hclk = ~Hclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push_exp(input string name, input logic [31:0] val);
        sb_q.push_back('{name, val});
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %h", act);
            return;
        end
        e = sb_q.pop_front();
        if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
    endtask

    // Setup-phase read: Prdata is combinational, so no clock edge is needed.
    task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string name);
        push_exp(name, exp);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = addr;
        #1;
        pop_cmp(Prdata);
        Psel = 1'b0; Paddr = '0;
    endtask

    task automatic chk_irq(input logic exp, input string name);
        push_exp(name, {31'd0, exp});
        pop_cmp({31'd0, Irq});
    endtask

    // Called at a falling edge; commits on the next-but-one rising edge, returns
    // on the falling edge just after the commit.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = addr; Pwdata = data;
        @(negedge Hclk);
        Penable = 1'b1;
        @(negedge Hclk);
        Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = addr;
        @(negedge Hclk);
        Penable = 1'b1;
        #1 data = Prdata;
        @(negedge Hclk);
        Psel = 1'b0; Penable = 1'b0;
    endtask

    // AHB single transfer: one address-phase cycle, then the bridge's setup + access.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge Hclk);
        apb_write(addr, data);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] hrdata);
        @(negedge Hclk);
        apb_read(addr, hrdata);
    endtask

    task automatic wait_exp(output time t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Hclk);
            Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0C;
            #1;
            if (Prdata[0]) begin
                ok = 1'b1;
                t  = $time;
                Psel = 1'b0;
                break;
            end
            Psel = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        time         t0, t1, t2;
        bit          ok;

        vecs[0]  = '{1'b1, 32'h04, 32'h0000_00A5, 32'h0, "load_wr"};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,         32'h0000_00A5, "load_rd"};
        vecs[2]  = '{1'b0, 32'h08, 32'h0,         32'h0000_00A5, "count_follows_load"};
        vecs[3]  = '{1'b1, 32'h14, 32'hFFFF_FFFF, 32'h0, "reserved_wr"};
        vecs[4]  = '{1'b0, 32'h14, 32'h0,         32'h0, "reserved_rd"};
        vecs[5]  = '{1'b0, 32'h40, 32'h0,         32'h0, "out_of_range_rd"};
        vecs[6]  = '{1'b1, 32'h10, 32'h0000_01F3, 32'h0, "prescale_wr"};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,         32'h0000_00F3, "prescale_rd"};
        vecs[8]  = '{1'b1, 32'h40, 32'h0000_0007, 32'h0, "out_of_range_wr"};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,         32'h0, "ctrl_after_oor_wr"};
        vecs[10] = '{1'b1, 32'h00, 32'hFFFF_FFFE, 32'h0, "ctrl_wr"};
        vecs[11] = '{1'b0, 32'h00, 32'h0,         32'h0000_0006, "ctrl_rd"};
        vecs[12] = '{1'b0, 32'h0C, 32'h0,         32'h0, "status_rd"};
        vecs[13] = '{1'b1, 32'h0C, 32'h0000_0001, 32'h0, "status_w1c_idle"};
        vecs[14] = '{1'b0, 32'h08, 32'h0,         32'h0000_00A5, "count_held_disabled"};

        Hreset = 1'b1; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
        Paddr = '0; Pwdata = '0;

        #5;
        peek(32'h04, 32'h0, "prdata_in_reset");
        chk_irq(1'b0, "irq_in_reset");
        @(negedge Hclk);
        @(negedge Hclk);
        Hreset = 1'b0;
        peek(32'h00, 32'h0, "ctrl_after_reset");
        peek(32'h08, 32'h0, "count_after_reset");

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                push_exp(vecs[i].name, vecs[i].exp);
                apb_read(vecs[i].addr, rd);
                pop_cmp(rd);
            end
        end

        // Access-phase signals without Psel must not commit.
        Psel = 1'b0; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'h77;
        @(negedge Hclk);
        Penable = 1'b0; Pwrite = 1'b0;
        peek(32'h04, 32'h0000_00A5, "write_without_psel");

        // One-shot, PRESCALE = 0: COUNT 3,2,1,0 then expiry clears EN.
        apb_write(32'h00, 32'h0);
        apb_write(32'h10, 32'h0);
        apb_write(32'h0C, 32'h1);
        apb_write(32'h04, 32'h3);
        apb_write(32'h00, 32'h5);
        for (int i = 0; i < 4; i++) begin
            peek(32'h08, 32'(3 - i), "oneshot_count");
            chk_irq(1'b0, "oneshot_irq_low");
            @(negedge Hclk);
        end
        peek(32'h08, 32'h0, "oneshot_count_zero");
        chk_irq(1'b1, "oneshot_irq");
        peek(32'h00, 32'h4, "oneshot_en_cleared");
        peek(32'h0C, 32'h1, "oneshot_exp");
        repeat (3) @(negedge Hclk);
        peek(32'h08, 32'h0, "oneshot_hold");

        // Auto-reload, LOAD = 2, PRESCALE = 3: expiry every 12 cycles.
        apb_write(32'h0C, 32'h1);
        apb_write(32'h04, 32'h2);
        apb_write(32'h10, 32'h3);
        apb_write(32'h00, 32'h7);
        t0 = $time;
        wait_exp(t1, ok);
        push_exp("first_expiry_seen", 32'h1); pop_cmp({31'd0, ok});
        push_exp("first_expiry_cycles", 32'd12); pop_cmp(32'((t1 - t0 - 1) / 20));
        peek(32'h08, 32'h2, "reload_count");
        chk_irq(1'b1, "reload_irq");
        apb_write(32'h0C, 32'h1);
        chk_irq(1'b0, "irq_after_w1c");
        peek(32'h0C, 32'h0, "status_after_w1c");
        wait_exp(t2, ok);
        push_exp("second_expiry_seen", 32'h1); pop_cmp({31'd0, ok});
        push_exp("reload_period_cycles", 32'd12); pop_cmp(32'((t2 - t1) / 20));
        // Clear now, then land a second W1C exactly on the next expiry edge.
        apb_write(32'h0C, 32'h1);
        repeat (8) @(negedge Hclk);
        apb_write(32'h0C, 32'h1);
        peek(32'h0C, 32'h1, "set_beats_w1c");
        chk_irq(1'b1, "irq_set_beats_w1c");

        // Collision: LOAD write on the reload-tick edge, IRQEN off.
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);
        apb_write(32'h04, 32'h2);
        apb_write(32'h10, 32'h0);
        apb_write(32'h00, 32'h3);
        @(negedge Hclk);
        apb_write(32'h04, 32'h9);
        peek(32'h08, 32'h9, "load_beats_reload");
        peek(32'h0C, 32'h1, "exp_on_collision");
        chk_irq(1'b0, "irq_masked");
        apb_write(32'h0C, 32'h1);
        peek(32'h0C, 32'h0, "w1c_no_irqen");
        peek(32'h08, 32'h7, "count_after_collision");
        for (int i = 0; i < 3; i++) begin
            chk_irq(1'b0, "irq_stays_low");
            @(negedge Hclk);
        end

        // Asynchronous reset mid-count with Irq high.
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);
        apb_write(32'h04, 32'h1);
        apb_write(32'h00, 32'h7);
        apb_write(32'h04, 32'hA);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Hclk);
            Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h08;
            #1;
            if (Prdata == 32'h5) begin
                ok = 1'b1;
                break;
            end
        end
        push_exp("count_reached_5", 32'h1); pop_cmp({31'd0, ok});
        chk_irq(1'b1, "irq_before_reset");
        #1 Hreset = 1'b1;
        #1;
        push_exp("prdata_async_reset", 32'h0); pop_cmp(Prdata);
        chk_irq(1'b0, "irq_async_reset");
        Psel = 1'b0;
        @(negedge Hclk);
        @(negedge Hclk);
        Hreset = 1'b0;
        peek(32'h08, 32'h0, "count_post_reset");
        peek(32'h00, 32'h0, "ctrl_post_reset");
        peek(32'h0C, 32'h0, "status_post_reset");
        peek(32'h04, 32'h0, "load_post_reset");

        // Bridge-style: COUNT read two edges after EN commit gives LOAD - 2.
        ahb_write(32'h04, 32'h20);
        ahb_write(32'h00, 32'h1);
        ahb_read(32'h08, rd);
        push_exp("bridge_hrdata", 32'h1E); pop_cmp(rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
